piso_tx: RTL



---
 rtl/piso_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter for the enable-qualified serial link.
// Takes a word over valid/ready and emits one bit per clock on sd, qualified by sen and sfirst.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_GAP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sd,
  output logic             sen,
  output logic             sfirst,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam bit NO_GAP = (IDLE_GAP == 0);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;

  logic             accept;
  logic             last_bit;
  logic             load_first;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  // The bit on the line leaves the shift register at load time, so shreg holds only what is still to send.
  assign load_first = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
  assign load_rest  = (MSB_FIRST != 0) ? (load_data << 1) : (load_data >> 1);
  assign next_bit   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign shifted    = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

  assign last_bit   = (state == SHIFT) && (bit_cnt == '0);
  assign load_ready = (state == IDLE) || (last_bit && NO_GAP);
  assign accept     = load_valid && load_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sd      <= 1'b0;
      sen     <= 1'b0;
      sfirst  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            shreg   <= load_rest;
            bit_cnt <= CNT_LOAD;
            sd      <= load_first;
            sen     <= 1'b1;
            sfirst  <= 1'b1;
          end else begin
            sd     <= 1'b0;
            sen    <= 1'b0;
            sfirst <= 1'b0;
          end
        end

        SHIFT: begin
          if (bit_cnt != '0) begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt - CW'(1);
            sd      <= next_bit;
            sen     <= 1'b1;
            sfirst  <= 1'b0;
          end else if (!NO_GAP) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
            sd      <= 1'b0;
            sen     <= 1'b0;
            sfirst  <= 1'b0;
          end else if (accept) begin
            // Streaming reload: the next word starts right after the last bit, no bubble.
            shreg   <= load_rest;
            bit_cnt <= CNT_LOAD;
            sd      <= load_first;
            sen     <= 1'b1;
            sfirst  <= 1'b1;
          end else begin
            state  <= IDLE;
            sd     <= 1'b0;
            sen    <= 1'b0;
            sfirst <= 1'b0;
          end
        end

        GAP: begin
          sd     <= 1'b0;
          sen    <= 1'b0;
          sfirst <= 1'b0;
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        default: begin
          state  <= IDLE;
          sd     <= 1'b0;
          sen    <= 1'b0;
          sfirst <= 1'b0;
        end
      endcase
    end
  end

endmodule
